// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the CPU fetch port.
// A fetch is accepted on an edge with READ high and completes LATENCY edges
// later; BUSYWAIT holds the CPU off until the requested word is valid.
// A full-word program-load port writes memory synchronously in any state.
// Optional feature: define IMEM_PREFETCH_EN to add a one-entry background
// prefetch of the word following each completed fetch.
module imem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              READ,
    input  logic [ADDR_W-1:0] ADDRESS,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [31:0]       LOAD_DATA
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int WORDS = 1 << WA_W;
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
    localparam logic [WA_W-1:0] WORD_ONE = WA_W'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [31:0]     mem [WORDS];
    state_t          state_q, state_d;
    logic [3:0]      counter_q, counter_d;
    logic [WA_W-1:0] addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;

    logic [WA_W-1:0] req_word_s, load_word_s;
    logic [31:0]     fwd_main_s, fwd_req_s;
    logic            launch_s, complete_s;
    logic            pf_hit_s, pf_track_s;
    logic [31:0]     pf_data_s;
    logic [3:0]      pf_cnt_s;
    logic            unused_ok_s;

    assign req_word_s  = ADDRESS[ADDR_W-1:2];
    assign load_word_s = LOAD_ADDR[ADDR_W-1:2];
    // Byte-offset bits are ignored: every access is a whole word.
    assign unused_ok_s = ^{ADDRESS[1:0], LOAD_ADDR[1:0]};

    // A load landing on the word being read at this edge wins over the stale array value.
    assign fwd_main_s = (LOAD_EN && (load_word_s == addr_q))     ? LOAD_DATA : mem[addr_q];
    assign fwd_req_s  = (LOAD_EN && (load_word_s == req_word_s)) ? LOAD_DATA : mem[req_word_s];

    assign INSTRUCTION = instr_q;
    assign BUSYWAIT    = READ & ~(valid_q & (req_word_s == addr_q));

    // Program-load port: full-word writes; contents survive reset.
    always_ff @(posedge CLK) begin
        if (LOAD_EN) begin
            mem[load_word_s] <= LOAD_DATA;
        end
    end

`ifdef IMEM_PREFETCH_EN
    logic            pf_busy_q, pf_busy_d, pf_valid_q, pf_valid_d;
    logic [WA_W-1:0] pf_addr_q, pf_addr_d;
    logic [3:0]      pf_cnt_q, pf_cnt_d;
    logic [31:0]     pf_data_q, pf_data_d, fwd_pf_s;
    logic            pf_load_hit_s;

    assign pf_load_hit_s = LOAD_EN && (load_word_s == pf_addr_q);
    assign fwd_pf_s      = pf_load_hit_s ? LOAD_DATA : mem[pf_addr_q];
    // A load to the buffered word invalidates it, so such a request misses.
    assign pf_hit_s      = pf_valid_q && !pf_load_hit_s && (req_word_s == pf_addr_q);
    assign pf_track_s    = pf_busy_q && !pf_load_hit_s && (req_word_s == pf_addr_q);
    assign pf_data_s     = pf_data_q;
    assign pf_cnt_s      = pf_cnt_q;

    // Prefetch next-state: relaunch after completions, cancel on new requests or loads, else count down.
    always_comb begin
        pf_busy_d  = pf_busy_q;
        pf_valid_d = pf_valid_q;
        pf_addr_d  = pf_addr_q;
        pf_cnt_d   = pf_cnt_q;
        pf_data_d  = pf_data_q;
        if (complete_s) begin
            pf_addr_d  = addr_d + WORD_ONE;
            pf_cnt_d   = CNT_INIT;
            pf_busy_d  = 1'b1;
            pf_valid_d = 1'b0;
        end else if (launch_s || pf_load_hit_s) begin
            pf_busy_d  = 1'b0;
            pf_valid_d = 1'b0;
        end else if (pf_busy_q && (pf_cnt_q == 4'd0)) begin
            pf_data_d  = fwd_pf_s;
            pf_valid_d = 1'b1;
            pf_busy_d  = 1'b0;
        end else if (pf_busy_q) begin
            pf_cnt_d = pf_cnt_q - 4'd1;
        end else begin
            pf_busy_d = 1'b0;
        end
    end

    // Prefetch buffer registers; reset empties the buffer.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pf_busy_q  <= 1'b0;
            pf_valid_q <= 1'b0;
            pf_addr_q  <= '0;
            pf_cnt_q   <= 4'd0;
            pf_data_q  <= 32'd0;
        end else begin
            pf_busy_q  <= pf_busy_d;
            pf_valid_q <= pf_valid_d;
            pf_addr_q  <= pf_addr_d;
            pf_cnt_q   <= pf_cnt_d;
            pf_data_q  <= pf_data_d;
        end
    end
`else
    assign pf_hit_s   = 1'b0;
    assign pf_track_s = 1'b0;
    assign pf_data_s  = 32'd0;
    assign pf_cnt_s   = 4'd0;
`endif

    // Fetch FSM next-state: accept, count down, complete, restart on address change.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        launch_s   = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (READ) begin
                    launch_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!READ) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (req_word_s != addr_q) begin
                    launch_s = 1'b1;
                end else if (counter_q == 4'd0) begin
                    instr_d    = fwd_main_s;
                    valid_d    = 1'b1;
                    state_d    = S_DONE;
                    complete_s = 1'b1;
                end else begin
                    counter_d = counter_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!READ) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (req_word_s != addr_q) begin
                    launch_s = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (launch_s) begin
            addr_d = req_word_s;
            if (pf_hit_s) begin
                instr_d    = pf_data_s;
                valid_d    = 1'b1;
                state_d    = S_DONE;
                complete_s = 1'b1;
            end else if (pf_track_s && (pf_cnt_s == 4'd0)) begin
                instr_d    = fwd_req_s;
                valid_d    = 1'b1;
                state_d    = S_DONE;
                complete_s = 1'b1;
            end else if (pf_track_s) begin
                counter_d = pf_cnt_s - 4'd1;
                valid_d   = 1'b0;
                state_d   = S_BUSY;
            end else if (LATENCY == 1) begin
                instr_d    = fwd_req_s;
                valid_d    = 1'b1;
                state_d    = S_DONE;
                complete_s = 1'b1;
            end else begin
                counter_d = CNT_INIT;
                valid_d   = 1'b0;
                state_d   = S_BUSY;
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Fetch FSM registers; asynchronous reset aborts any fetch in flight.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            counter_q <= 4'd0;
            addr_q    <= '0;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the processor's fetch interface; the memory side of the PC/INSTRUCTION path.
- Accepts word-fetch requests from the CPU and returns the 32-bit instruction after a fixed multi-cycle latency, holding the CPU off with BUSYWAIT.
- Includes a synchronous program-load port so benches and boot logic can fill memory without hierarchical writes.

Parameters:
- ADDR_W, 10, byte-address width; memory size is 2^ADDR_W bytes, organised as 2^(ADDR_W-2) 32-bit words.
- LATENCY, 4, clock edges from request acceptance to data valid; legal range 1..15.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- READ  input  1  fetch request, held high by the CPU until BUSYWAIT is low.
- ADDRESS  input  ADDR_W  byte address of the fetch; bits [1:0] are ignored (word-aligned).
- INSTRUCTION  output  32  fetched word, big-endian: byte at ADDRESS goes to [31:24], byte at ADDRESS+3 goes to [7:0].
- BUSYWAIT  output  1  high while a READ is outstanding and its data is not yet valid.
- LOAD_EN  input  1  program-load write strobe.
- LOAD_ADDR  input  ADDR_W  byte address of the load; bits [1:0] are ignored.
- LOAD_DATA  input  32  word to store, same byte order as INSTRUCTION.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, INSTRUCTION=0, valid=0, counter=0, addr_q=0.
  - Memory contents are NOT cleared.
  - Reset asserted mid-fetch aborts the fetch; after release, a still-high READ starts a new fetch.
- States:
  - IDLE: at an edge with READ=1, latch addr_q=ADDRESS[ADDR_W-1:2], counter=LATENCY-1, go to BUSY (or straight to DONE when LATENCY=1).
  - BUSY: each edge decrements counter. At the edge where counter==0, register INSTRUCTION=mem[addr_q], set valid=1, go to DONE.
  - DONE: INSTRUCTION holds. At an edge with READ=0, go to IDLE and keep INSTRUCTION. At an edge with READ=1 and a word address different from addr_q, start a new fetch (as from IDLE) and set valid=0.
- BUSYWAIT is combinational: READ & ~(valid & (ADDRESS word == addr_q)).
  - It rises in the same cycle READ rises or the address changes.
  - It falls after the completing edge.
- Latency: request sampled at edge k means data valid and BUSYWAIT low after edge k+LATENCY.
- Address change while BUSY: abort and restart at that edge with the new address and a full counter. The old data is never presented.
- LOAD_EN: synchronous write of the full word at the edge.
  - Legal in any state; does not alter the state machine.
  - If a load hits addr_q at the completing edge, INSTRUCTION takes LOAD_DATA (forwarded).
  - If a load hits addr_q while DONE, INSTRUCTION is not updated; the CPU re-fetches.
- Address arithmetic is modulo 2^(ADDR_W-2) words; the last word +1 wraps to word 0.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- Defined:
  - After any fetch of word A completes, a one-entry prefetch buffer fetches word A+1 (wrapping) in the background with LATENCY cycles.
  - A request for A+1 hits once the prefetch is complete: BUSYWAIT drops after one edge (data registered at the accepting edge). That fetch then launches the next prefetch.
  - A request for A+1 during an in-flight prefetch waits only for the remaining prefetch count.
  - A request for any other address cancels the prefetch.
  - A LOAD to the buffered word, or reset, invalidates the buffer.
- Undefined: no buffer; every fetch costs LATENCY edges.

Test Plan:
- Reset, preload word 0 = 0x00010003 via LOAD, READ=1 ADDRESS=0 -> BUSYWAIT high for exactly 4 edges, then INSTRUCTION=0x00010003, BUSYWAIT=0.
- Sequential fetch 0,4,8 with READ held high and the address stepped when BUSYWAIT falls -> each word returned after 4 edges. With IMEM_PREFETCH_EN, the fetches of 4 and 8 complete after 1 edge when requested ≥4 edges after the prior completion.
- ADDRESS changes 16->32 two edges into a fetch -> no data for 16; data for 32 returned 4 edges after the change.
- Reset pulsed mid-fetch at edge 2 -> INSTRUCTION=0 and BUSYWAIT tracks READ immediately; after release, a full 4-edge fetch completes.
- LOAD word 8 = 0x07020401 on the completing edge of a fetch of 8 -> INSTRUCTION=0x07020401; with prefetch, a load to the buffered word forces a full-latency fetch.
- ADDRESS=0x3FC fetch then prefetch (IMEM_PREFETCH_EN) -> buffer holds word 0; a request to 0 hits in 1 edge.
